bp_fe_ras_ctrl: RTL and testbench
=================================

BP_FE_RAS_CTRL -- requirements
Module: bp_fe_ras_ctrl

Interface
REQ-001 Parameter vaddr_width_p, default 16: width of PC and return-address values; matches the stack data width.
REQ-002 Parameter els_p, default 8: capacity of the attached return-address stack.
REQ-003 Parameter inst_bytes_p, default 4: byte size of a call instruction; return address = pc_i + inst_bytes_p.
REQ-004 Parameter ovf_width_p, default 4: width of the overflow-drop counter.
REQ-005 clk_i  in  1  single clock; all state updates on posedge clk_i.
REQ-006 reset_i  in  1  reset, synchronous and active-high.
REQ-007 v_i  in  1  branch-class event valid this cycle.
REQ-008 call_i  in  1  event is a call; qualified by v_i.
REQ-009 ret_i  in  1  event is a return; qualified by v_i.
REQ-010 pc_i  in  vaddr_width_p  PC of the event instruction.
REQ-011 flush_i  in  1  frontend redirect; discard all stack contents.
REQ-012 push_o  out  1  push command to stack.
REQ-013 w_data_o  out  vaddr_width_p  push data to stack.
REQ-014 pop_o  out  1  pop command to stack.
REQ-015 r_data_i  in  vaddr_width_p  stack read data; combinational, valid in the pop cycle.
REQ-016 pred_v_o  out  1  registered return-target prediction valid.
REQ-017 pred_target_o  out  vaddr_width_p  registered predicted return target.
REQ-018 busy_o  out  1  controller draining; events not accepted.
REQ-019 underflow_o  out  1  registered one-cycle pulse on unpredictable return.

Function
REQ-020 State: FSM {IDLE, DRAIN}; depth counter 0..els_p; ovf_cnt 0..2^ovf_width_p-1, saturating.
REQ-021 Events are accepted only in IDLE with v_i=1 and flush_i=0; otherwise push_o=pop_o=0 from event logic.
REQ-022 Call only, depth<els_p: push_o=1, w_data_o=pc_i+inst_bytes_p (modulo 2^vaddr_width_p); depth+1.
REQ-023 Call only, depth==els_p: push_o=0; ovf_cnt+1 (saturating); depth unchanged.
REQ-024 Ret only, ovf_cnt>0: pop_o=0; ovf_cnt-1; next-cycle pred_v_o=0; underflow_o=0.
REQ-025 Ret only, ovf_cnt==0, depth>0: pop_o=1; depth-1; next cycle pred_v_o=1, pred_target_o=r_data_i captured in the pop cycle.
REQ-026 Ret only, ovf_cnt==0, depth==0: pop_o=0; next cycle pred_v_o=0, underflow_o=1 for exactly one cycle.
REQ-027 Call and ret together, depth>0, ovf_cnt==0: push_o=pop_o=1, w_data_o=pc_i+inst_bytes_p; depth unchanged; next cycle pred_v_o=1, pred_target_o=pc_i+inst_bytes_p.
REQ-028 Call and ret together with depth==0 or ovf_cnt>0: handled as call only (REQ-022/023).
REQ-029 pred_v_o is 0 in any cycle not following an accepted popping return; pred_target_o holds its last value when pred_v_o=0.
REQ-030 flush_i in IDLE: ovf_cnt cleared next cycle; events that cycle are ignored; if depth>0 then go to DRAIN, else remain IDLE.
REQ-031 DRAIN: busy_o=1; pop_o=1, push_o=0 each cycle; depth-1 each cycle; pred_v_o=0; go to IDLE in the cycle depth reaches 0.
REQ-032 DRAIN lasts exactly the depth value held at flush; flush_i and v_i are ignored during DRAIN.
REQ-033 The attached stack pointer and depth always agree; push_o and pop_o are never issued so that the stack over- or underflows.

Reset
REQ-034 reset_i forces, next cycle: state IDLE, depth 0, ovf_cnt 0, pred_v_o=0, pred_target_o=0, underflow_o=0, busy_o=0.
REQ-035 Reset mid-DRAIN aborts draining immediately; the stack is reset by the same reset_i.
REQ-036 During reset cycles push_o=pop_o=0.

Verification
REQ-037 Push/pop: calls at pc 0x0100, then 0x0200; ret; ret -> pred_target_o 0x0204 then 0x0104, pred_v_o=1 each, depth 0 after.
REQ-038 Overflow: 10 calls (els_p=8) then 10 rets -> first 2 rets give pred_v_o=0 with no pop; next 8 pop in LIFO order; depth 0.
REQ-039 Underflow: ret at depth 0 -> pop_o=0, underflow_o high for one cycle, pred_v_o=0.
REQ-040 Flush: 5 calls, then flush_i -> busy_o high exactly 5 cycles, 5 pops, then IDLE, depth 0, ovf_cnt 0.
REQ-041 Simultaneous: depth 3 with call+ret at pc 0x0300 -> push_o=pop_o=1, depth stays 3, pred_target_o 0x0304.
REQ-042 Reset during DRAIN at depth 4 -> next cycle busy_o=0, pop_o=0, depth 0.

Source files
------------

// File: rtl/bp_fe_ras_ctrl.sv
// rtl/bp_fe_ras_ctrl.sv - return-address-stack controller: push/pop sequencing, overflow tracking, flush drain
module bp_fe_ras_ctrl #(
    parameter int vaddr_width_p = 16,
    parameter int els_p         = 8,
    parameter int inst_bytes_p  = 4,
    parameter int ovf_width_p   = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic                     call_i,
    input  logic                     ret_i,
    input  logic [vaddr_width_p-1:0] pc_i,
    input  logic                     flush_i,
    output logic                     push_o,
    output logic [vaddr_width_p-1:0] w_data_o,
    output logic                     pop_o,
    input  logic [vaddr_width_p-1:0] r_data_i,
    output logic                     pred_v_o,
    output logic [vaddr_width_p-1:0] pred_target_o,
    output logic                     busy_o,
    output logic                     underflow_o
);

    localparam int depth_width_lp = $clog2(els_p + 1);
    localparam logic [depth_width_lp-1:0] els_lp = depth_width_lp'(els_p);

    typedef enum logic {
        e_idle,
        e_drain
    } state_e;

    state_e                     state_r, state_n;
    logic [depth_width_lp-1:0]  depth_r, depth_n;
    logic [ovf_width_p-1:0]     ovf_r, ovf_n;
    logic                       pred_v_n;
    logic [vaddr_width_p-1:0]   pred_target_n;
    logic                       underflow_n;
    logic [vaddr_width_p-1:0]   ret_addr;

    assign ret_addr = pc_i + vaddr_width_p'(inst_bytes_p);

    always_comb begin
        state_n       = state_r;
        depth_n       = depth_r;
        ovf_n         = ovf_r;
        push_o        = 1'b0;
        pop_o         = 1'b0;
        pred_v_n      = 1'b0;
        pred_target_n = pred_target_o;
        underflow_n   = 1'b0;
        busy_o        = (state_r == e_drain);
        w_data_o      = ret_addr;

        if (state_r == e_drain) begin
            pop_o   = 1'b1;
            depth_n = depth_r - 1'b1;
            if (depth_r == depth_width_lp'(1))
                state_n = e_idle;
        end else if (flush_i) begin
            ovf_n = '0;
            if (depth_r != '0)
                state_n = e_drain;
        end else if (v_i) begin
            // Call+ret replaces the top entry in place; the new address is also the prediction
            if (call_i && ret_i && depth_r != '0 && ovf_r == '0) begin
                push_o        = 1'b1;
                pop_o         = 1'b1;
                pred_v_n      = 1'b1;
                pred_target_n = ret_addr;
            end else if (call_i) begin
                if (depth_r < els_lp) begin
                    push_o  = 1'b1;
                    depth_n = depth_r + 1'b1;
                end else if (ovf_r != '1) begin
                    ovf_n = ovf_r + 1'b1;
                end
            end else if (ret_i) begin
                // Returns matching dropped calls are consumed before touching the stack
                if (ovf_r != '0) begin
                    ovf_n = ovf_r - 1'b1;
                end else if (depth_r != '0) begin
                    pop_o         = 1'b1;
                    depth_n       = depth_r - 1'b1;
                    pred_v_n      = 1'b1;
                    pred_target_n = r_data_i;
                end else begin
                    underflow_n = 1'b1;
                end
            end
        end

        if (reset_i) begin
            push_o = 1'b0;
            pop_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r       <= e_idle;
            depth_r       <= '0;
            ovf_r         <= '0;
            pred_v_o      <= 1'b0;
            pred_target_o <= '0;
            underflow_o   <= 1'b0;
        end else begin
            state_r       <= state_n;
            depth_r       <= depth_n;
            ovf_r         <= ovf_n;
            pred_v_o      <= pred_v_n;
            pred_target_o <= pred_target_n;
            underflow_o   <= underflow_n;
        end
    end

endmodule

// File: tb/tb_bp_fe_ras_ctrl.sv
// tb/tb_bp_fe_ras_ctrl.sv - directed and randomized checks of bp_fe_ras_ctrl against a queue-based model
module tb_bp_fe_ras_ctrl;

    localparam int W   = 16;
    localparam int ELS = 8;

    logic          clk_i = 1'b0;
    logic          reset_i, v_i, call_i, ret_i, flush_i;
    logic [W-1:0]  pc_i, r_data_i, w_data_o, pred_target_o;
    logic          push_o, pop_o, pred_v_o, busy_o, underflow_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bp_fe_ras_ctrl dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .call_i(call_i), .ret_i(ret_i),
        .pc_i(pc_i), .flush_i(flush_i), .push_o(push_o), .w_data_o(w_data_o),
        .pop_o(pop_o), .r_data_i(r_data_i), .pred_v_o(pred_v_o),
        .pred_target_o(pred_target_o), .busy_o(busy_o), .underflow_o(underflow_o)
    );

    // Attached stack: follows the controller's push/pop commands
    logic [W-1:0] stk [0:ELS-1];
    int           sp = 0;

    always_comb begin
        r_data_i = '0;
        if (sp > 0 && sp <= ELS) r_data_i = stk[sp-1];
    end

    always @(posedge clk_i) begin
        if (reset_i) begin
            sp <= 0;
        end else if (push_o && pop_o) begin
            if (sp > 0 && sp <= ELS) stk[sp-1] <= w_data_o;
        end else if (push_o) begin
            if (sp >= 0 && sp < ELS) stk[sp] <= w_data_o;
            sp <= sp + 1;
        end else if (pop_o) begin
            sp <= sp - 1;
        end
    end

    // Reference model: list of pending return addresses plus count of dropped calls
    logic [W-1:0] m_q [$];
    int           m_ovf, m_drain;
    logic         m_pred_v, m_uf;
    logic [W-1:0] m_pred_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic c, input logic r,
                        input logic [W-1:0] pc, input logic fl);
        logic         e_push, e_pop, e_busy;
        logic [W-1:0] ra;
        reset_i = rst; v_i = v; call_i = c; ret_i = r; pc_i = pc; flush_i = fl;
        #2;
        ra     = pc + 16'd4;
        e_push = 1'b0;
        e_pop  = 1'b0;
        e_busy = (m_drain > 0);
        m_pred_v = 1'b0;
        m_uf     = 1'b0;
        if (rst) begin
            m_q.delete();
            m_ovf = 0; m_drain = 0; m_pred_t = '0;
        end else if (m_drain > 0) begin
            e_pop = 1'b1;
            void'(m_q.pop_back());
            m_drain--;
        end else if (fl) begin
            m_ovf   = 0;
            m_drain = m_q.size();
        end else if (v) begin
            if (c && r && m_q.size() > 0 && m_ovf == 0) begin
                e_push = 1'b1; e_pop = 1'b1;
                m_q[m_q.size()-1] = ra;
                m_pred_v = 1'b1; m_pred_t = ra;
            end else if (c) begin
                if (m_q.size() < ELS) begin
                    e_push = 1'b1;
                    m_q.push_back(ra);
                end else if (m_ovf < 15) begin
                    m_ovf++;
                end
            end else if (r) begin
                if (m_ovf > 0) begin
                    m_ovf--;
                end else if (m_q.size() > 0) begin
                    e_pop = 1'b1;
                    m_pred_v = 1'b1;
                    m_pred_t = m_q.pop_back();
                end else begin
                    m_uf = 1'b1;
                end
            end
        end
        chk("push_o", push_o, e_push);
        chk("pop_o", pop_o, e_pop);
        chk("busy_o", busy_o, e_busy);
        if (e_push) chk("w_data_o", w_data_o, ra);
        chk("stack_over", push_o && !pop_o && sp >= ELS, 0);
        chk("stack_under", pop_o && sp <= 0, 0);
        @(posedge clk_i);
        #1;
        chk("pred_v_o", pred_v_o, m_pred_v);
        chk("pred_target_o", pred_target_o, m_pred_t);
        chk("underflow_o", underflow_o, m_uf);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, 0);
    endtask

    initial begin
        int phase_call;
        int rr;
        reset_i = 1'b1; v_i = 0; call_i = 0; ret_i = 0; pc_i = '0; flush_i = 0;
        m_ovf = 0; m_drain = 0; m_pred_v = 0; m_uf = 0; m_pred_t = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_pred_v", pred_v_o, 0);
        chk("rst_pred_t", pred_target_o, 0);
        chk("rst_uf", underflow_o, 0);
        chk("rst_busy", busy_o, 0);
        step(1, 1, 1, 0, 16'h0040, 0);
        chk("rst_push_gated", sp, 0);

        // Nested call/return
        step(0, 1, 1, 0, 16'h0100, 0);
        step(0, 1, 1, 0, 16'h0200, 0);
        step(0, 1, 0, 1, 16'h0abc, 0);
        chk("lifo_t1", pred_target_o, 16'h0204);
        step(0, 1, 0, 1, 16'h0abc, 0);
        chk("lifo_t2", pred_target_o, 16'h0104);
        chk("lifo_depth", sp, 0);

        // Overflow: two dropped calls absorb the first two returns
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, W'(16'h1000 + 16 * i), 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 16'h0000, 0);
        chk("ovf_depth", sp, 0);

        // Underflow pulse
        step(0, 1, 0, 1, 16'h0000, 0);
        chk("uf_pulse", underflow_o, 1);
        idle();
        chk("uf_clear", underflow_o, 0);

        // Flush with five entries drains for five cycles
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, W'(16'h2000 + 4 * i), 0);
        step(0, 1, 1, 0, 16'h5555, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1, '0, 1);
        idle();
        chk("flush_depth", sp, 0);

        // Simultaneous call+ret at depth 3
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, W'(16'h3000 + 8 * i), 0);
        step(0, 1, 1, 1, 16'h0300, 0);
        chk("sim_target", pred_target_o, 16'h0304);
        chk("sim_depth", sp, 3);
        step(0, 0, 0, 0, '0, 1);
        for (int i = 0; i < 3; i++) idle();

        // Reset during drain at depth 4
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, W'(16'h4000 + 4 * i), 0);
        step(0, 0, 0, 0, '0, 1);
        idle();
        step(1, 0, 0, 0, '0, 0);
        idle();
        chk("rst_drain_depth", sp, 0);

        // Randomized traffic with alternating call-heavy and return-heavy phases
        phase_call = 1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 60 == 0) phase_call = $urandom_range(0, 1);
            rr = $urandom_range(0, 99);
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) < 7,
                 phase_call ? (rr < 75) : (rr < 25),
                 phase_call ? (rr >= 65) : (rr >= 20),
                 W'($urandom),
                 $urandom_range(0, 59) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
